// File: rtl/led_ctrl_csr_slave_pkg.sv
// Shared constants for the LED control CSR slave: register map, mode codes, STATUS layout.
// No logic of its own; zero latency.
// No flow control; used only at elaboration time.
package led_ctrl_pkg;

    // Word addresses of the four CSRs
    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_TOGGLE = 2'd1;
    localparam logic [1:0] ADDR_WDOG   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // LED modes as seen by the downstream blink stage
    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_ON        = 2'b01,
        MODE_HOLD      = 2'b10,
        MODE_SW_TOGGLE = 2'b11
    } mode_e;

    // STATUS register layout
    localparam int STATUS_EXPIRED_BIT = 0;
    localparam int STATUS_MODE_LSB    = 2;
    localparam int STATUS_MODE_MSB    = 3;

    // Assemble the STATUS read word; all undefined bits read as zero
    function automatic logic [31:0] status_word(input logic expired, input logic [1:0] mode);
        logic [31:0] w;
        w = '0;
        w[STATUS_EXPIRED_BIT] = expired;
        w[STATUS_MODE_MSB:STATUS_MODE_LSB] = mode;
        return w;
    endfunction

endpackage

// File: rtl/led_ctrl_csr_slave_if.sv
// Avalon-MM CSR bus bundle between a host (master) and the LED control slave.
// Read data returns one cycle after the read request; writes take effect at the accepting edge.
// No waitrequest: the slave accepts every request, so the master never stalls.
interface led_ctrl_csr_slave_if;

    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata,
        output avs_readdatavalid
    );

endinterface

// File: rtl/led_ctrl_csr_slave_wdog.sv
// Host-inactivity watchdog: counts idle cycles since the last kick and flags reaching the limit.
// expire is combinational, asserted in the cycle before wcnt lands on the limit (one cycle wide).
// No backpressure; kick always wins over counting, but never suppresses a due expiry.
module led_ctrl_wdog (
    input  logic        clock_sink_clk,
    input  logic        reset_sink_reset,
    input  logic        kick,
    input  logic [31:0] limit,
    output logic        expire
);

    logic [31:0] wcnt;
    logic [31:0] wcnt_nxt;
    logic [32:0] wcnt_inc;
    logic        enabled;
    logic        at_limit;

    // Expiry when the next count would reach (or a lowered limit already sits below) wcnt
    always_comb begin
        wcnt_inc = {1'b0, wcnt} + 33'd1;
        enabled  = (limit != 32'd0);
        at_limit = (wcnt == limit);
        expire   = enabled && !at_limit && (wcnt_inc >= {1'b0, limit});
    end

    // Next count: cleared by kick or disable, parked at the limit once reached
    always_comb begin
        wcnt_nxt = wcnt_inc[31:0];
        if (!enabled || kick) begin
            wcnt_nxt = 32'd0;
        end else if (expire || at_limit) begin
            wcnt_nxt = limit;
        end
    end

    // Idle-cycle counter
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            wcnt <= 32'd0;
        end else begin
            wcnt <= wcnt_nxt;
        end
    end

endmodule

// File: rtl/led_ctrl_csr_slave.sv
// Avalon-MM CSR slave owning LED mode, toggle strobe/counter and the inactivity watchdog.
// Writes land at the accepting edge; reads return registered data exactly one cycle later.
// Never stalls (no waitrequest); a read colliding with a write is dropped.
module led_ctrl_csr_slave
    import led_ctrl_pkg::*;
#(
    parameter logic [31:0] WDOG_DEFAULT = 32'd0,
    parameter int          CNT_W        = 16
) (
    input  logic                 clock_sink_clk,
    input  logic                 reset_sink_reset,
    led_ctrl_csr_slave_if.slave  avs,
    output logic [1:0]           blink_flag,
    output logic                 csr_write,
    output logic                 wdog_irq
);

    mode_e             mode;
    logic [CNT_W-1:0]  tcnt;
    logic [31:0]       limit;
    logic              expired;
    logic              expire;
    logic              toggle_q;
    logic [31:0]       readdata_q;
    logic              rvalid_q;

    logic              wr_mode;
    logic              wr_toggle;
    logic              wr_wdog;
    logic              wr_status;
    logic              rd_accept;
    logic [31:0]       rd_mux;

    // Address decode; a write in the same cycle as a read suppresses the read
    always_comb begin
        wr_mode   = avs.avs_write && (avs.avs_address == ADDR_MODE);
        wr_toggle = avs.avs_write && (avs.avs_address == ADDR_TOGGLE);
        wr_wdog   = avs.avs_write && (avs.avs_address == ADDR_WDOG);
        wr_status = avs.avs_write && (avs.avs_address == ADDR_STATUS);
        rd_accept = avs.avs_read && !avs.avs_write;
    end

    led_ctrl_wdog u_wdog (
        .clock_sink_clk   (clock_sink_clk),
        .reset_sink_reset (reset_sink_reset),
        .kick             (avs.avs_write),
        .limit            (limit),
        .expire           (expire)
    );

    // MODE register: a host write beats a simultaneous watchdog force-off
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            mode <= MODE_OFF;
        end else if (wr_mode) begin
            mode <= mode_e'(avs.avs_writedata[1:0]);
        end else if (expire) begin
            mode <= MODE_OFF;
        end
    end

    // TOGGLE: one strobe cycle and one count per write, regardless of mode
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            toggle_q <= 1'b0;
            tcnt     <= '0;
        end else begin
            toggle_q <= wr_toggle;
            if (wr_toggle) begin
                tcnt <= tcnt + CNT_W'(1);
            end
        end
    end

    // WDOG_LIMIT register
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            limit <= WDOG_DEFAULT;
        end else if (wr_wdog) begin
            limit <= avs.avs_writedata;
        end
    end

    // Sticky expired flag: a new expiry beats a same-cycle write-1-to-clear
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && avs.avs_writedata[STATUS_EXPIRED_BIT]) begin
            expired <= 1'b0;
        end
    end

    // Read mux over pre-update register state
    always_comb begin
        rd_mux = 32'd0;
        case (avs.avs_address)
            ADDR_MODE:   rd_mux = {30'd0, mode};
            ADDR_TOGGLE: rd_mux = 32'(tcnt);
            ADDR_WDOG:   rd_mux = limit;
            default:     rd_mux = status_word(expired, mode);
        endcase
    end

    // Registered read response, fixed latency of one cycle
    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            readdata_q <= 32'd0;
            rvalid_q   <= 1'b0;
        end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
    assign blink_flag            = mode;
    assign csr_write             = toggle_q;
    assign wdog_irq              = expired;

endmodule

// File: tb/tb_led_ctrl_csr_slave.sv
// Self-checking bench for led_ctrl_csr_slave: read data checked through an expected-value queue.
// Inputs driven 1ns after the rising edge; read responses sampled on the falling edge.
// The DUT never stalls, so every wait is a fixed cycle count.
module tb_led_ctrl_csr_slave;
    import led_ctrl_pkg::*;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] WDOG_DEF = 32'd0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] blink_flag;
    logic       csr_write;
    logic       wdog_irq;

    led_ctrl_csr_slave_if bus ();

    led_ctrl_csr_slave #(
        .WDOG_DEFAULT (WDOG_DEF),
        .CNT_W        (CNT_W)
    ) dut (
        .clock_sink_clk   (clk),
        .reset_sink_reset (rst),
        .avs              (bus),
        .blink_flag       (blink_flag),
        .csr_write        (csr_write),
        .wdog_irq         (wdog_irq)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    // Reference model of host-visible register state
    logic [1:0]       m_mode;
    logic [CNT_W-1:0] m_tcnt;
    logic [31:0]      m_limit;
    logic             m_expired;

    // Scoreboard: each readdatavalid pops one expected word
    always @(negedge clk) begin
        if (bus.avs_readdatavalid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stray_rvalid: readdatavalid=1 with no read pending at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.avs_readdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL read_data: got %08h expected %08h at %0t", bus.avs_readdata, mon_exp, $time);
                end
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_mode};
            2'd1:    return 32'(m_tcnt);
            2'd2:    return m_limit;
            default: return {28'd0, m_mode, 1'b0, m_expired};
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 2'b00; m_tcnt = '0; m_limit = WDOG_DEF; m_expired = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        bus.avs_address = 2'd0; bus.avs_writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0;
        case (a)
            2'd0:    m_mode = d[1:0];
            2'd1:    m_tcnt = m_tcnt + 1'b1;
            2'd2:    m_limit = d;
            default: if (d[0]) m_expired = 1'b0;
        endcase
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp_val);
        bus.avs_address = a; bus.avs_read = 1'b1;
        exp_q.push_back(exp_val);
        @(posedge clk);
        #1;
        bus.avs_read = 1'b0;
        n_tests++;
        if (bus.avs_readdatavalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency: readdatavalid=%b expected 1 one cycle after read of addr %0d", bus.avs_readdatavalid, a);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({blink_flag, csr_write, wdog_irq, bus.avs_readdatavalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: blink=%b csr_write=%b irq=%b rvalid=%b expected all 0", blink_flag, csr_write, wdog_irq, bus.avs_readdatavalid);
        end
        n_tests++;
        if (bus.avs_readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %08h expected 0", bus.avs_readdata);
        end
        bus_read(ADDR_MODE,   32'd0);
        bus_read(ADDR_TOGGLE, 32'd0);
        bus_read(ADDR_WDOG,   WDOG_DEF);
        bus_read(ADDR_STATUS, 32'd0);
    endtask

    task automatic test_modes();
        for (int v = 0; v < 4; v++) begin
            bus_write(ADDR_MODE, ($urandom() & 32'hFFFF_FFFC) | 32'(v));
            n_tests++;
            if (blink_flag !== 2'(v)) begin
                n_fail++;
                $display("FAIL mode_%0d: blink_flag=%b expected %b", v, blink_flag, 2'(v));
            end
            bus_read(ADDR_MODE, model_read(ADDR_MODE));
            bus_read(ADDR_STATUS, 32'(v) << 2);
        end
        // STATUS ignores writes to bits other than the W1C flag
        bus_write(ADDR_STATUS, 32'hFFFF_FFF2);
        bus_read(ADDR_STATUS, model_read(ADDR_STATUS));
        bus_write(ADDR_WDOG, 32'h0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_write(ADDR_MODE, 32'h3);
        n_tests++;
        if (blink_flag !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_mode: blink_flag=%b expected 11", blink_flag);
        end
        bus.avs_address = ADDR_TOGGLE; bus.avs_writedata = $urandom(); bus.avs_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            m_tcnt = m_tcnt + 1'b1;
            n_tests++;
            if (csr_write !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_pulse_%0d: csr_write=%b expected 1", i, csr_write);
            end
        end
        bus.avs_write = 1'b0;
        idle(1);
        n_tests++;
        if (csr_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse_end: csr_write=%b expected 0", csr_write);
        end
        bus_read(ADDR_TOGGLE, 32'd3);
        bus_read(ADDR_MODE, 32'd3);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) bus_write(ADDR_TOGGLE, $urandom());
        bus_read(ADDR_TOGGLE, 32'd1);
    endtask

    task automatic test_wr_rd_collision();
        do_reset();
        bus.avs_address = ADDR_MODE; bus.avs_writedata = 32'h2;
        bus.avs_write = 1'b1; bus.avs_read = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        m_mode = 2'b10;
        n_tests++;
        if (bus.avs_readdatavalid !== 1'b0 || blink_flag !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_rd_collision: rvalid=%b blink=%b expected rvalid=0 blink=10", bus.avs_readdatavalid, blink_flag);
        end
        idle(2);
    endtask

    task automatic test_watchdog();
        do_reset();
        bus_write(ADDR_WDOG, 32'd10);
        bus_write(ADDR_MODE, 32'd1);
        for (int k = 1; k <= 11; k++) begin
            n_tests++;
            if (blink_flag !== ((k <= 10) ? 2'b01 : 2'b00) || wdog_irq !== (k == 11)) begin
                n_fail++;
                $display("FAIL wdog_cycle_%0d: blink=%b irq=%b expected blink=%b irq=%b", k, blink_flag, wdog_irq, (k <= 10) ? 2'b01 : 2'b00, k == 11);
            end
            if (k < 11) idle(1);
        end
        m_mode = 2'b00; m_expired = 1'b1;
        bus_read(ADDR_STATUS, 32'h1);
        bus_write(ADDR_STATUS, 32'h1);
        n_tests++;
        if (wdog_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_w1c: irq=%b expected 0", wdog_irq);
        end
        bus_write(ADDR_WDOG, 32'd0);
    endtask

    task automatic test_expiry_collision();
        do_reset();
        bus_write(ADDR_WDOG, 32'd10);
        bus_write(ADDR_MODE, 32'd1);
        idle(9);
        bus_write(ADDR_MODE, 32'd1);
        m_expired = 1'b1;
        n_tests++;
        if (blink_flag !== 2'b01 || wdog_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL expire_vs_mode: blink=%b irq=%b expected blink=01 irq=1", blink_flag, wdog_irq);
        end
        idle(9);
        n_tests++;
        if (blink_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL wcnt_restart: blink=%b expected 01 one cycle before second expiry", blink_flag);
        end
        bus_write(ADDR_STATUS, 32'h1);
        m_expired = 1'b1; m_mode = 2'b00;
        n_tests++;
        if (wdog_irq !== 1'b1 || blink_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL expire_vs_w1c: irq=%b blink=%b expected irq=1 blink=00", wdog_irq, blink_flag);
        end
        bus_read(ADDR_STATUS, 32'h1);
        bus_write(ADDR_WDOG, 32'd0);
    endtask

    task automatic test_reset_midop();
        bus_write(ADDR_MODE, 32'd1);
        bus.avs_address = ADDR_MODE; bus.avs_read = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_read = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.avs_readdatavalid !== 1'b0 || bus.avs_readdata !== 32'd0 || blink_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_read: rvalid=%b data=%08h blink=%b expected all 0", bus.avs_readdatavalid, bus.avs_readdata, blink_flag);
        end
        idle(2);
        rst = 1'b0;
        model_reset();
        bus_write(ADDR_TOGGLE, 32'd0);
        rst = 1'b1;
        #1;
        n_tests++;
        if (csr_write !== 1'b0 || wdog_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: csr_write=%b irq=%b expected 0", csr_write, wdog_irq);
        end
        idle(2);
        rst = 1'b0;
        model_reset();
        idle(3);
        bus_read(ADDR_TOGGLE, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        bus.avs_address = 2'd0; bus.avs_writedata = 32'd0;
        model_reset();
        test_reset();
        test_modes();
        test_back_to_back();
        test_wrap();
        test_wr_rd_collision();
        test_watchdog();
        test_expiry_collision();
        test_reset_midop();
        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_rvalid: %0d reads never answered, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_ctrl_csr_slave.md
# led_ctrl_csr_slave

Avalon-MM CSR slave that owns the LED control registers and drives the LED blink control stage directly downstream. It decodes host writes into a registered 2-bit `blink_flag` mode and a single-cycle `csr_write` toggle strobe. It keeps a toggle event counter. A host-inactivity watchdog forces the LED off if software stops writing.

## Interface
- `WDOG_DEFAULT`, 32'd0: reset value of the WDOG_LIMIT register; 0 means the watchdog is disabled.
- `CNT_W`, 16: width of the toggle event counter; legal range 1–32.
- `clock_sink_clk`  in  1  system clock.
- `reset_sink_reset`  in  1  reset, asynchronous, active-high; clock clock_sink_clk.
- `avs_address`  in  2  word address.
- `avs_write`  in  1  write request.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read request.
- `avs_readdata`  out  32  read data, registered.
- `avs_readdatavalid`  out  1  read data valid strobe.
- `blink_flag`  out  2  LED mode to the downstream stage.
- `csr_write`  out  1  one-cycle toggle strobe to the downstream stage.
- `wdog_irq`  out  1  level interrupt; equals the sticky expired flag.

## Operation
Register map (word address):
- 0 MODE: RW, bits[1:0], reset 00.
  - Encodings: 00 OFF, 01 ON, 10 HOLD, 11 SW_TOGGLE.
  - All four values are stored as written; there is no remapping.
  - Bits[31:2] read as 0.
- 1 TOGGLE: a write of any data pulses `csr_write` and increments the toggle counter.
  - The counter is CNT_W bits and wraps from all-ones to 0.
  - A read returns the counter, zero-extended.
  - The pulse is issued in every mode; gating by mode is the consumer's job.
- 2 WDOG_LIMIT: RW, 32 bits, reset WDOG_DEFAULT.
- 3 STATUS:
  - bit0 `expired`: sticky, write-1-to-clear.
  - bits[3:2]: current mode, read-only.
  - Other bits read as 0 and ignore writes.

Watchdog (32-bit counter `wcnt`):
- When the limit is 0: `wcnt` is held at 0 and never expires.
- Any accepted write, to any address, clears `wcnt` to 0.
- Otherwise `wcnt` increments each cycle until it equals the limit.
- On the cycle `wcnt` first equals the limit:
  - MODE is forced to 00.
  - `expired` is set.
  - `wcnt` holds at the limit; there is no re-fire until the next write.
- If the limit is written below the current `wcnt` value, that immediately counts as reaching the limit.

Simultaneous events:
- `avs_write` and `avs_read` in the same cycle: the write is performed and the read is dropped (no `readdatavalid`).
- Watchdog expiry in the same cycle as a MODE write: the write wins, MODE takes the written value, and `wcnt` is cleared. `expired` is still set.
- W1C of `expired` in the same cycle as a new expiry: set wins.
- An out-of-range write has no effect. All addresses are decoded, so this cannot occur.

## Timing
- Reset values of all outputs are 0: `blink_flag`=00, `csr_write`=0, `avs_readdata`=0, `avs_readdatavalid`=0, `wdog_irq`=0.
- Reset values of internal state: `wcnt`=0, toggle counter=0, `expired`=0.
- The slave never stalls; there is no waitrequest.
- Write accepted at rising edge N: the register takes the new value at edge N, visible during cycle N+1.
- `csr_write` is high for exactly cycle N+1.
- Back-to-back TOGGLE writes give one `csr_write` pulse per write, consecutive cycles high.
- Fixed read latency of 1:
  - A read accepted at edge N gives `avs_readdatavalid`=1 and data during cycle N+1.
  - The data reflects register state before any same-edge update.
- Watchdog timing: with limit L≥1 and the last write at edge N, `blink_flag` goes to 00 and `wdog_irq` rises during cycle N+L+1.
- Reset asserted mid-operation: all state and outputs clear asynchronously, and any in-flight read completes with no `readdatavalid`.

## Structure
- Package `led_ctrl_pkg` holds:
  - Address constants ADDR_MODE=0, ADDR_TOGGLE=1, ADDR_WDOG=2, ADDR_STATUS=3.
  - Mode encodings MODE_OFF, MODE_ON, MODE_HOLD, MODE_SW_TOGGLE.
  - STATUS bit positions.
- Sub-module `led_ctrl_wdog` contains the counter, limit compare and expire pulse.
  - Inputs: clock, reset, `kick`, `limit[31:0]`.
  - Output: one-cycle `expire`.
- The top level owns register decode, read mux and strobes.

## Test plan
- Reset, then read addresses 0–3 → 0, 0, WDOG_DEFAULT, 0; `readdatavalid` exactly 1 cycle after each read.
- Write MODE=11, then three back-to-back TOGGLE writes → `blink_flag`=11, three consecutive `csr_write` pulses, TOGGLE read returns 3.
- With CNT_W=4, issue 17 TOGGLE writes → read returns 1.
- WDOG_LIMIT=10, MODE=01, no further writes:
  - Required: `blink_flag` drops to 00 and `wdog_irq`=1 exactly 11 cycles after the MODE write edge.
  - Then STATUS reads 0x1.
  - Then writing STATUS=1 clears `wdog_irq`.
- Force a MODE=01 write on the expiry cycle → `blink_flag`=01, `expired`=1, `wcnt` restarts from 0.
- Assert reset mid-read and during a `csr_write` pulse → all outputs drop to 0 immediately, with no stray `readdatavalid` after release.
